// File: rtl/stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard unit: Tuse/forward encodings,
// shadow-stage records, and the stall-condition helpers.
package stall_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } e_stage_t;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [4:0] rt;
    } m_stage_t;

    // Tnew counts down by one per stage and never wraps below zero.
    function automatic logic [1:0] tnew_dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    function automatic logic hz(
        input logic [4:0] r,
        input logic [1:0] t,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew
    );
        return (t != TUSE_NONE) && (r != 5'd0) &&
               (((e_a3 == r) && (e_tnew > t)) || ((m_a3 == r) && (m_tnew > t)));
    endfunction

endpackage

// File: rtl/stall_ctrl_fwd_pick.sv
// Forward-source picker: scans up to three candidate stages, youngest first (E, M, W),
// and selects the first one writing the requested register if its result is ready.
module fwd_pick
    import stall_ctrl_pkg::*;
(
    input  logic [4:0]      addr,
    input  logic [2:0][4:0] cand_a3,
    input  logic [2:0][1:0] cand_tnew,
    input  logic [2:0]      en,
    output logic [1:0]      sel
);

    logic found;

    always_comb begin
        sel   = FWD_RF;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // A newest matching writer that is not ready blocks older stages.
            if (!found && en[i] && (cand_a3[i] == addr)) begin
                found = 1'b1;
                if (cand_tnew[i] == 2'd0) begin
                    sel = 2'(i + 1);
                end
            end
        end
        if (addr == 5'd0) begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/stall_ctrl.sv
// Hazard unit: shadow E/M/W destination pipeline, stall request, forwarding selects
// and a saturating stalled-cycle counter.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic [1:0]       rs_tuse,
    input  logic [1:0]       rt_tuse,
    input  logic [4:0]       d_a3,
    input  logic [1:0]       d_tnew,
    output logic             stall,
    output logic [1:0]       fwd_rs_d,
    output logic [1:0]       fwd_rt_d,
    output logic [1:0]       fwd_rs_e,
    output logic [1:0]       fwd_rt_e,
    output logic             fwd_rt_m,
    output logic [CNT_W-1:0] stall_cnt
);

    e_stage_t   e_q;
    m_stage_t   m_q;
    logic [4:0] w_a3;

    logic [2:0][4:0] cand_a3;
    logic [2:0][1:0] cand_tnew;

    always_comb begin
        stall = hz(d_rs, rs_tuse, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew) |
                hz(d_rt, rt_tuse, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q       <= '0;
            m_q       <= '0;
            w_a3      <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall) begin
                e_q <= '0;
            end else begin
                e_q <= '{a3: d_a3, tnew: d_tnew, rs: d_rs, rt: d_rt};
            end
            m_q  <= '{a3: e_q.a3, tnew: tnew_dec(e_q.tnew), rt: e_q.rt};
            w_a3 <= m_q.a3;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    // Candidate order is E, M, W; W results are always ready.
    assign cand_a3   = {w_a3, m_q.a3, e_q.a3};
    assign cand_tnew = {2'd0, m_q.tnew, e_q.tnew};

    fwd_pick u_pick_rs_d (
        .addr      (d_rs),
        .cand_a3   (cand_a3),
        .cand_tnew (cand_tnew),
        .en        (3'b111),
        .sel       (fwd_rs_d)
    );

    fwd_pick u_pick_rt_d (
        .addr      (d_rt),
        .cand_a3   (cand_a3),
        .cand_tnew (cand_tnew),
        .en        (3'b111),
        .sel       (fwd_rt_d)
    );

    fwd_pick u_pick_rs_e (
        .addr      (e_q.rs),
        .cand_a3   (cand_a3),
        .cand_tnew (cand_tnew),
        .en        (3'b110),
        .sel       (fwd_rs_e)
    );

    fwd_pick u_pick_rt_e (
        .addr      (e_q.rt),
        .cand_a3   (cand_a3),
        .cand_tnew (cand_tnew),
        .en        (3'b110),
        .sel       (fwd_rt_e)
    );

    assign fwd_rt_m = (w_a3 == m_q.rt) && (m_q.rt != 5'd0);

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: load-use, branch-use, store-data forwarding,
// r0 handling, reset during stall, and counter saturation on a narrow instance.
module tb_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_a3;
    logic [1:0] rs_tuse, rt_tuse, d_tnew;

    logic        stall, fwd_rt_m;
    logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic [31:0] stall_cnt;

    logic        stall2, fwd_rt_m2;
    logic [1:0]  fwd_rs_d2, fwd_rt_d2, fwd_rs_e2, fwd_rt_e2;
    logic [1:0]  stall_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stall_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
        .rs_tuse(rs_tuse), .rt_tuse(rt_tuse), .d_a3(d_a3), .d_tnew(d_tnew),
        .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
        .stall_cnt(stall_cnt)
    );

    stall_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
        .rs_tuse(rs_tuse), .rt_tuse(rt_tuse), .d_a3(d_a3), .d_tnew(d_tnew),
        .stall(stall2), .fwd_rs_d(fwd_rs_d2), .fwd_rt_d(fwd_rt_d2),
        .fwd_rs_e(fwd_rs_e2), .fwd_rt_e(fwd_rt_e2), .fwd_rt_m(fwd_rt_m2),
        .stall_cnt(stall_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [1:0] rsu,
                         input logic [4:0] rt, input logic [1:0] rtu,
                         input logic [4:0] a3, input logic [1:0] tn);
        d_rs = rs; rs_tuse = rsu; d_rt = rt; rt_tuse = rtu; d_a3 = a3; d_tnew = tn;
        #1;
    endtask

    task automatic nop();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nop();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        nop();

        // Reset state
        do_reset();
        chk("rst_stall", stall, 0);
        chk("rst_fwd_rs_d", fwd_rs_d, 0);
        chk("rst_fwd_rt_d", fwd_rt_d, 0);
        chk("rst_fwd_rs_e", fwd_rs_e, 0);
        chk("rst_fwd_rt_e", fwd_rt_e, 0);
        chk("rst_fwd_rt_m", fwd_rt_m, 0);
        chk("rst_cnt", stall_cnt, 0);

        // lw $1 then addu rs=1: one stall, then W forward in E
        drive(5'd2, 2'd1, 5'd0, 2'd3, 5'd1, 2'd2);
        chk("lw_stall", stall, 0);
        tick();
        drive(5'd1, 2'd1, 5'd0, 2'd1, 5'd3, 2'd1);
        chk("lwuse_stall1", stall, 1);
        chk("lwuse_fwd_rs_d", fwd_rs_d, 0);
        tick();
        chk("lwuse_stall2", stall, 0);
        tick();
        nop();
        chk("lwuse_fwd_rs_e", fwd_rs_e, 3);
        chk("lwuse_cnt", stall_cnt, 1);

        // addu $5 then beq rs=5: one stall, then M forward in D
        do_reset();
        drive(5'd1, 2'd1, 5'd2, 2'd1, 5'd5, 2'd1);
        chk("alu_stall", stall, 0);
        tick();
        drive(5'd5, 2'd0, 5'd6, 2'd0, 5'd0, 2'd0);
        chk("beq_stall1", stall, 1);
        tick();
        chk("beq_stall2", stall, 0);
        chk("beq_fwd_rs_d", fwd_rs_d, 2);
        chk("beq_fwd_rt_d", fwd_rt_d, 0);
        tick();
        chk("beq_cnt", stall_cnt, 1);

        // lw $7 then sw rt=7: no stall, E waits, M takes from W
        do_reset();
        drive(5'd3, 2'd1, 5'd0, 2'd3, 5'd7, 2'd2);
        tick();
        drive(5'd4, 2'd1, 5'd7, 2'd2, 5'd0, 2'd0);
        chk("sw_stall", stall, 0);
        tick();
        nop();
        chk("sw_fwd_rt_e", fwd_rt_e, 0);
        chk("sw_fwd_rt_m_early", fwd_rt_m, 0);
        tick();
        chk("sw_fwd_rt_m", fwd_rt_m, 1);
        chk("sw_cnt", stall_cnt, 0);

        // r0 is never a hazard nor forwarded
        do_reset();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2);
        tick();
        drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
        chk("r0_stall", stall, 0);
        chk("r0_fwd_rs_d", fwd_rs_d, 0);
        chk("r0_fwd_rt_d", fwd_rt_d, 0);

        // Reset asserted on a stalling edge clears everything
        do_reset();
        drive(5'd2, 2'd1, 5'd0, 2'd3, 5'd1, 2'd2);
        tick();
        drive(5'd1, 2'd1, 5'd0, 2'd3, 5'd3, 2'd1);
        chk("rstmid_stall_pre", stall, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(5'd1, 2'd0, 5'd1, 2'd0, 5'd0, 2'd0);
        chk("rstmid_stall", stall, 0);
        chk("rstmid_cnt", stall_cnt, 0);
        chk("rstmid_fwd_rs_d", fwd_rs_d, 0);
        tick();
        nop();
        chk("rstmid_fwd_rs_e", fwd_rs_e, 0);
        chk("rstmid_fwd_rt_m", fwd_rt_m, 0);

        // Five stalls: lw->beq (2), lw->beq (2), lw->addu (1)
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(5'd2, 2'd1, 5'd0, 2'd3, 5'd1, 2'd2);
            tick();
            drive(5'd1, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
            chk("lwbeq_stall_a", stall, 1);
            tick();
            chk("lwbeq_stall_b", stall, 1);
            tick();
            chk("lwbeq_stall_c", stall, 0);
            tick();
        end
        chk("sat_cnt4", stall_cnt, 4);
        chk("sat_cnt4_narrow", stall_cnt2, 3);
        drive(5'd2, 2'd1, 5'd0, 2'd3, 5'd1, 2'd2);
        tick();
        drive(5'd1, 2'd1, 5'd0, 2'd3, 5'd3, 2'd1);
        chk("sat_last_stall", stall, 1);
        tick();
        nop();
        tick();
        chk("sat_cnt5", stall_cnt, 5);
        chk("sat_cnt5_narrow", stall_cnt2, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
